// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with a 12-op ALU, a data-SRAM request and an iterative HI/LO divider
module ex_stage #(
  parameter int ID_TO_EX_WD = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int DIV_STEPS = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_id_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);
  localparam int CW = $clog2(DIV_STEPS + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  logic [ID_TO_EX_WD-1:0] ex_r;
  logic [31:0] pc, inst, rs_val, rt_val, a, b, alu_res, result, sra_res, hi, lo;
  logic [11:0] alu_op;
  logic [2:0] src1;
  logic [3:0] src2, ram_wen;
  logic [4:0] rf_waddr;
  logic ram_en, rf_we, sel_rf_res, is_sp, is_div, is_divs, is_mfhi, is_mflo, slt, sltu, unused;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] rem, quo, dvs, abs_rs, abs_rt;
  logic [32:0] sh, diff;
  logic ge, neg_q, neg_r, dz, done_flag, ld;
  assign {pc, inst, alu_op, src1, src2, ram_en, ram_wen, rf_we, rf_waddr, sel_rf_res, rs_val, rt_val} = ex_r;
  assign ld = ~(stall[2] & stall[3]);
  assign unused = ^{inst[25:16], stall[5:4], stall[1:0]};
  assign a = ({32{src1[0]}} & rs_val) | ({32{src1[1]}} & pc) | ({32{src1[2]}} & {27'b0, inst[10:6]});
  assign b = ({32{src2[0]}} & rt_val) | ({32{src2[1]}} & {{16{inst[15]}}, inst[15:0]})
           | ({32{src2[2]}} & 32'd8) | ({32{src2[3]}} & {16'b0, inst[15:0]});
  assign slt = $signed(a) < $signed(b);
  assign sltu = a < b;
  assign sra_res = $signed(b) >>> a[4:0];
  assign alu_res = ({32{alu_op[11]}} & (a + b)) | ({32{alu_op[10]}} & (a - b))
                 | ({32{alu_op[9]}} & {31'b0, slt}) | ({32{alu_op[8]}} & {31'b0, sltu})
                 | ({32{alu_op[7]}} & (a & b)) | ({32{alu_op[6]}} & ~(a | b))
                 | ({32{alu_op[5]}} & (a | b)) | ({32{alu_op[4]}} & (a ^ b))
                 | ({32{alu_op[3]}} & (b << a[4:0])) | ({32{alu_op[2]}} & (b >> a[4:0]))
                 | ({32{alu_op[1]}} & sra_res) | ({32{alu_op[0]}} & {b[15:0], 16'b0});
  assign is_sp = inst[31:26] == 6'd0;
  assign is_divs = is_sp & (inst[5:0] == 6'h1A);
  assign is_div = is_divs | (is_sp & (inst[5:0] == 6'h1B));
  assign is_mfhi = is_sp & (inst[5:0] == 6'h10);
  assign is_mflo = is_sp & (inst[5:0] == 6'h12);
  assign result = is_mfhi ? hi : is_mflo ? lo : alu_res;
  assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, result};
  assign ex_to_id_bus = ex_to_mem_bus;
  assign data_sram_en = ram_en;
  assign data_sram_wen = ram_wen;
  assign data_sram_addr = result;
  assign data_sram_wdata = rt_val;
  assign stallreq_for_ex = is_div & ~done_flag & (state != DONE);
  assign abs_rs = (is_divs & rs_val[31]) ? -rs_val : rs_val;
  assign abs_rt = (is_divs & rt_val[31]) ? -rt_val : rt_val;
  // one restoring step: shift the next dividend bit into the partial remainder
  assign sh = {rem, quo[31]};
  assign diff = sh - {1'b0, dvs};
  assign ge = sh >= {1'b0, dvs};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ex_r <= '0;
    else if (stall[2] & ~stall[3]) ex_r <= '0;
    else if (~stall[2]) ex_r <= id_to_ex_bus;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      {rem, quo, dvs, hi, lo} <= '0;
      {neg_q, neg_r, dz, done_flag} <= '0;
    end else begin
      done_flag <= ld ? 1'b0 : (state == DONE) | done_flag;
      case (state)
        IDLE: if (is_div & ~done_flag) begin
          rem <= '0;
          quo <= abs_rs;
          dvs <= abs_rt;
          neg_q <= is_divs & (rs_val[31] ^ rt_val[31]);
          neg_r <= is_divs & rs_val[31];
          dz <= rt_val == 32'd0;
          cnt <= '0;
          state <= BUSY;
        end
        BUSY: begin
          rem <= ge ? diff[31:0] : sh[31:0];
          quo <= {quo[30:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DIV_STEPS - 1)) state <= DONE;
        end
        DONE: begin
          hi <= neg_r ? -rem : rem;
          lo <= dz ? 32'hFFFF_FFFF : neg_q ? -quo : quo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
